// File: rtl/formant_frame_sched.sv
// rtl/formant_frame_sched.sv - frame scheduler between the FFT magnitude stream and the formant engine
//
// Aligns the FFT sample stream into I-bin frames, forwards one eligible frame
// at a time to the formant engine, then holds off until the engine reports
// done (or the watchdog expires) and resets the engine before the next frame.
//
// Ports:
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   fft_valid_in/data/last  incoming sample stream (last marks the final bin)
//   eng_valid_out/data_out  forwarded samples, one register stage behind input
//   eng_rst_out             active-high engine reset, high while in ENG_RST
//   eng_done_in             engine formant_valid
//   busy_out                high whenever the scheduler is not IDLE
//   frame_done_out          one-cycle pulse per completed frame
//   frames_ok_out           completed frames, saturating
//   frames_drop_out         dropped, aborted or timed-out frames, saturating
//   frame_err_out           sticky early-last flag
//   timeout_err_out         sticky watchdog flag
module formant_frame_sched #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int TIMEOUT   = 1048576,
    parameter int DECIM     = 1,
    parameter int RST_CYC   = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 fft_valid_in,
    input  logic [BIT_WIDTH-1:0] fft_data_in,
    input  logic                 fft_last_in,
    output logic                 eng_valid_out,
    output logic [BIT_WIDTH-1:0] eng_data_out,
    output logic                 eng_rst_out,
    input  logic                 eng_done_in,
    output logic                 busy_out,
    output logic                 frame_done_out,
    output logic [15:0]          frames_ok_out,
    output logic [15:0]          frames_drop_out,
    output logic                 frame_err_out,
    output logic                 timeout_err_out
);

    localparam int BIN_W = (I > 1) ? $clog2(I) : 1;
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int RC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ENG_RST,
        IDLE,
        STREAM,
        WAIT_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [BIN_W-1:0] bin_cnt;
    logic [DEC_W-1:0] dec_cnt;
    logic [RC_W-1:0]  rst_cnt;
    logic [WD_W-1:0]  wd_cnt;

    logic bin_last;
    logic frame_start;
    logic early_last;
    logic eligible;
    logic fwd;
    logic ok_inc;
    logic abort_drop;
    logic busy_drop;
    logic to_set;
    logic [1:0]  drop_inc;
    logic [16:0] drop_sum;

    assign bin_last    = (bin_cnt == BIN_W'(I - 1));
    assign frame_start = fft_valid_in && (bin_cnt == '0);
    assign early_last  = fft_valid_in && fft_last_in && !bin_last;
    assign eligible    = frame_start && (dec_cnt == '0);

    // A start that would have been eligible but finds the engine occupied is
    // a lost frame; this can coincide with a watchdog abort, hence two bits.
    assign busy_drop = eligible && ((state == WAIT_DONE) || (state == ENG_RST));
    assign drop_inc  = {1'b0, abort_drop} + {1'b0, busy_drop};
    assign drop_sum  = {1'b0, frames_drop_out} + {15'b0, drop_inc};

    assign eng_rst_out = (state == ENG_RST);
    assign busy_out    = (state != IDLE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state   <= ENG_RST;
            rst_cnt <= '0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            rst_cnt <= ((state == ENG_RST) && (state_nxt == ENG_RST)) ? rst_cnt + 1'b1 : '0;
            wd_cnt  <= (state == WAIT_DONE) ? wd_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt  = state;
        fwd        = 1'b0;
        ok_inc     = 1'b0;
        abort_drop = 1'b0;
        to_set     = 1'b0;
        case (state)
            ENG_RST: begin
                if (rst_cnt == RC_W'(RST_CYC - 1)) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                // An early last on the start bin ends the frame before any
                // sample reaches the engine; the engine is still re-armed.
                if (eligible) begin
                    if (early_last) begin
                        abort_drop = 1'b1;
                        state_nxt  = ENG_RST;
                    end else begin
                        fwd       = 1'b1;
                        state_nxt = bin_last ? WAIT_DONE : STREAM;
                    end
                end
            end
            STREAM: begin
                // The early-last sample itself is withheld so that no valid
                // reaches the engine while its reset is asserted.
                if (fft_valid_in) begin
                    if (early_last) begin
                        abort_drop = 1'b1;
                        state_nxt  = ENG_RST;
                    end else begin
                        fwd = 1'b1;
                        if (bin_last) begin
                            state_nxt = WAIT_DONE;
                        end
                    end
                end
            end
            WAIT_DONE: begin
                if (eng_done_in) begin
                    ok_inc    = 1'b1;
                    state_nxt = ENG_RST;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    to_set     = 1'b1;
                    abort_drop = 1'b1;
                    state_nxt  = ENG_RST;
                end
            end
            default: state_nxt = ENG_RST;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bin_cnt         <= '0;
            dec_cnt         <= '0;
            eng_valid_out   <= 1'b0;
            eng_data_out    <= '0;
            frame_done_out  <= 1'b0;
            frames_ok_out   <= '0;
            frames_drop_out <= '0;
            frame_err_out   <= 1'b0;
            timeout_err_out <= 1'b0;
        end else begin
            if (fft_valid_in) begin
                bin_cnt <= (fft_last_in || bin_last) ? '0 : bin_cnt + 1'b1;
            end
            if (frame_start) begin
                dec_cnt <= (dec_cnt == DEC_W'(DECIM - 1)) ? '0 : dec_cnt + 1'b1;
            end
            eng_valid_out <= fwd;
            if (fwd) begin
                eng_data_out <= fft_data_in;
            end
            frame_done_out <= ok_inc;
            if (ok_inc && (frames_ok_out != 16'hFFFF)) begin
                frames_ok_out <= frames_ok_out + 1'b1;
            end
            frames_drop_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (early_last) begin
                frame_err_out <= 1'b1;
            end
            if (to_set) begin
                timeout_err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_formant_frame_sched.sv
// tb/tb_formant_frame_sched.sv - scoreboard bench for formant_frame_sched with a frame-level reference model
module tb_formant_frame_sched;

    localparam int BW  = 32;
    localparam int NB  = 160;
    localparam int TMO = 1024;
    localparam int DEC = 2;
    localparam int RC  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fv;
    logic          fl;
    logic [BW-1:0] fd;
    logic          done;
    logic          eng_valid;
    logic [BW-1:0] eng_data;
    logic          eng_rst;
    logic          busy;
    logic          frame_done;
    logic [15:0]   ok_cnt;
    logic [15:0]   drop_cnt;
    logic          ferr;
    logic          terr;

    always #5 clk = ~clk;

    formant_frame_sched #(
        .BIT_WIDTH(BW), .I(NB), .TIMEOUT(TMO), .DECIM(DEC), .RST_CYC(RC)
    ) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .fft_valid_in    (fv),
        .fft_data_in     (fd),
        .fft_last_in     (fl),
        .eng_valid_out   (eng_valid),
        .eng_data_out    (eng_data),
        .eng_rst_out     (eng_rst),
        .eng_done_in     (done),
        .busy_out        (busy),
        .frame_done_out  (frame_done),
        .frames_ok_out   (ok_cnt),
        .frames_drop_out (drop_cnt),
        .frame_err_out   (ferr),
        .timeout_err_out (terr)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Scoreboard: expected forwarded samples with the edge that must register
    // them, and the edges at which frame_done must be registered.
    logic [BW-1:0] exp_data[$];
    int            exp_edge[$];
    int            done_q[$];

    // Reference model: stream position, decimation phase, what the engine
    // holds (0 nothing, 1 receiving, 2 computing), and the first edge at which
    // a start finds the scheduler idle again.
    int m_bin, m_dec, m_hold, m_wstart, m_ready, m_ok, m_drop;
    bit m_ferr, m_terr;
    int done_at;

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : 65535;
    endfunction

    task automatic model_edge(input int s, input bit v, input bit last, input logic [BW-1:0] d, input bit dn);
        int pre;
        bit idle, start, at_end, early, elig;
        pre  = m_hold;
        idle = (pre == 0) && (s >= m_ready);
        if (v) begin
            start  = (m_bin == 0);
            at_end = (m_bin == NB - 1);
            early  = last && !at_end;
            if (early) m_ferr = 1;
            if (start) begin
                elig  = (m_dec == 0);
                m_dec = (m_dec + 1) % DEC;
                if (elig && idle) begin
                    if (early) begin
                        m_drop  = sat_inc(m_drop);
                        m_ready = s + RC + 1;
                    end else begin
                        exp_data.push_back(d);
                        exp_edge.push_back(s);
                        m_hold = 1;
                    end
                end else if (elig) begin
                    m_drop = sat_inc(m_drop);
                end
            end else if (pre == 1) begin
                if (early) begin
                    m_drop  = sat_inc(m_drop);
                    m_ready = s + RC + 1;
                    m_hold  = 0;
                end else begin
                    exp_data.push_back(d);
                    exp_edge.push_back(s);
                    if (at_end) begin
                        m_hold   = 2;
                        m_wstart = s + 1;
                    end
                end
            end
            m_bin = (last || at_end) ? 0 : m_bin + 1;
        end
        if (pre == 2) begin
            if (dn) begin
                m_ok = sat_inc(m_ok);
                done_q.push_back(s);
                m_ready = s + RC + 1;
                m_hold  = 0;
            end else if (s == m_wstart + TMO - 1) begin
                m_terr  = 1;
                m_drop  = sat_inc(m_drop);
                m_ready = s + RC + 1;
                m_hold  = 0;
            end
        end
    endtask

    // Called one time unit after a rising edge; inputs are sampled at the next edge.
    task automatic drive(input bit v, input bit last, input logic [BW-1:0] d);
        int s;
        bit dn;
        s    = edge_cnt + 1;
        dn   = (s == done_at);
        fv   = v;
        fl   = last;
        fd   = d;
        done = dn;
        model_edge(s, v, last, d, dn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) drive(1'b0, 1'b0, '0);
    endtask

    // done_delay > 0 schedules eng_done that many edges after the last bin,
    // 0 cancels any pending done, < 0 leaves the schedule untouched.
    task automatic send_frame(input int nb, input int early_bin, input bit with_last,
                              input int gap_pct, input int done_delay);
        bit lst;
        for (int b = 0; b < nb; b++) begin
            while ($urandom_range(0, 99) < gap_pct) drive(1'b0, 1'b0, '0);
            lst = (b == early_bin) || (with_last && (b == NB - 1));
            drive(1'b1, lst, $urandom);
            if (b == early_bin) break;
        end
        if (done_delay > 0) done_at = edge_cnt + done_delay;
        else if (done_delay == 0) done_at = -1;
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (!(m_hold == 0 && edge_cnt + 1 >= m_ready) && n < TMO + 200) begin
            drive(1'b0, 1'b0, '0);
            n++;
        end
        if (n >= TMO + 200) check("settle_bound", 1, 0);
        fv   = 1'b0;
        fl   = 1'b0;
        done = 1'b0;
        @(negedge clk);
        check("frames_ok", ok_cnt, m_ok);
        check("frames_drop", drop_cnt, m_drop);
        check("frame_err", ferr, m_ferr);
        check("timeout_err", terr, m_terr);
        check("busy_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic align_dec();
        if (m_dec != 0) begin
            send_frame(NB, -1, 1'b1, 0, -1);
            settle();
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        fv      = 1'b0;
        fl      = 1'b0;
        done    = 1'b0;
        done_at = -1;
        #1;
        check("rst_valid", eng_valid, 0);
        check("rst_eng_rst", eng_rst, 1);
        check("rst_busy", busy, 1);
        check("rst_data", eng_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_ok", ok_cnt, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ferr", ferr, 0);
        check("rst_terr", terr, 0);
        m_bin = 0; m_dec = 0; m_hold = 0; m_ok = 0; m_drop = 0;
        m_ferr = 0; m_terr = 0;
        exp_data.delete();
        exp_edge.delete();
        done_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_ready = edge_cnt + 1 + RC;
        for (int k = 0; k < RC; k++) begin
            @(negedge clk);
            check("rst_pulse_high", eng_rst, 1);
        end
        @(negedge clk);
        check("rst_pulse_low", eng_rst, 0);
        check("idle_after_rst", busy, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (eng_valid) begin
                check("valid_during_rst", eng_rst, 0);
                if (exp_data.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    check("fwd_data", eng_data, exp_data.pop_front());
                    check("fwd_edge", edge_cnt, exp_edge.pop_front());
                end
            end else if (exp_edge.size() > 0 && exp_edge[0] <= edge_cnt) begin
                check("missing_valid", 0, 1);
                void'(exp_data.pop_front());
                void'(exp_edge.pop_front());
            end
            if (frame_done) begin
                if (done_q.size() == 0) check("unexpected_done", 1, 0);
                else check("done_edge", edge_cnt, done_q.pop_front());
            end else if (done_q.size() > 0 && done_q[0] <= edge_cnt) begin
                check("missing_done", 0, 1);
                void'(done_q.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int kind, dd;
        rst_n = 1'b0; fv = 1'b0; fl = 1'b0; fd = '0; done = 1'b0; done_at = -1;
        @(posedge clk);
        #1;
        do_reset();

        // One frame, engine done 500 cycles after the last bin.
        send_frame(NB, -1, 1'b1, 20, 500);
        settle();

        // Back-to-back frames while the engine is busy, then a fresh frame.
        send_frame(NB, -1, 1'b1, 0, 1000);
        send_frame(NB, -1, 1'b1, 0, -1);
        send_frame(NB, -1, 1'b1, 0, -1);
        settle();
        align_dec();
        send_frame(NB, -1, 1'b1, 0, 5);
        settle();

        // Early last at bin 99, then a normal frame.
        align_dec();
        send_frame(NB, 99, 1'b1, 0, -1);
        settle();
        align_dec();
        send_frame(NB, -1, 1'b1, 10, 3);
        settle();

        // Watchdog expiry, then done exactly on the expiry cycle.
        align_dec();
        send_frame(NB, -1, 1'b1, 0, 0);
        settle();
        align_dec();
        send_frame(NB, -1, 1'b1, 0, TMO);
        settle();
        align_dec();
        send_frame(NB, -1, 1'b0, 5, TMO + 1);
        settle();

        // Start landing on the ENG_RST to IDLE transition cycle.
        align_dec();
        send_frame(NB, -1, 1'b1, 0, NB - 1);
        send_frame(NB, -1, 1'b1, 0, -1);
        while (edge_cnt + 1 < m_ready - 1) drive(1'b0, 1'b0, '0);
        send_frame(NB, -1, 1'b1, 0, -1);
        settle();

        // Reset in the middle of a forwarded frame.
        align_dec();
        send_frame(50, -1, 1'b0, 0, -1);
        do_reset();
        settle();

        // Randomized traffic.
        for (int it = 0; it < 25; it++) begin
            kind = $urandom_range(0, 9);
            if (kind < 5)      dd = $urandom_range(1, 30);
            else if (kind < 7) dd = $urandom_range(100, 600);
            else if (kind < 8) dd = TMO;
            else if (kind < 9) dd = TMO + 1;
            else               dd = 0;
            send_frame(NB, ($urandom_range(0, 9) == 0) ? $urandom_range(0, NB - 2) : -1,
                       $urandom_range(0, 3) != 0, $urandom_range(0, 30), dd);
            if ($urandom_range(0, 3) != 0) idle_cycles($urandom_range(1, 300));
            if ($urandom_range(0, 4) == 0) settle();
        end
        settle();
        check("sb_data_empty", exp_data.size(), 0);
        check("sb_done_empty", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
